// File: rtl/pwm_decoder_if.sv
// PWM measurement bus: the raw PWM input plus the decoded duty code and status.
interface pwm_decoder_if #(
  parameter int unsigned PWM_WIDTH = 4
);
  logic                 pwm_in;
  logic [PWM_WIDTH-1:0] duty;
  logic                 duty_valid;
  logic                 locked;

  modport master (output pwm_in, input duty, duty_valid, locked);
  modport slave  (input pwm_in, output duty, duty_valid, locked);
endinterface

// File: rtl/pwm_decoder.sv
// Measures an incoming PWM waveform and reports duty as floor(high/period * 2^W),
// with stuck-high/stuck-low detection by timeout.
module pwm_decoder #(
  parameter int unsigned CLK_HZ          = 12_000_000,
  parameter int unsigned PWM_PERIOD_US   = 100,
  parameter int unsigned PWM_WIDTH       = 4,
  parameter int unsigned PWM_TICKS       = CLK_HZ * PWM_PERIOD_US / 1_000_000,
  parameter int unsigned TIMEOUT_PERIODS = 4,
  parameter int unsigned CNT_W           = $clog2(PWM_TICKS * TIMEOUT_PERIODS + 1)
) (
  input  logic         clk,
  input  logic         rst,
  pwm_decoder_if.slave bus
);
  localparam int unsigned      W       = PWM_WIDTH;
  localparam int unsigned      DCW     = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(PWM_TICKS * TIMEOUT_PERIODS);
  localparam logic [CNT_W-1:0] MIN_DEN = CNT_W'(W + 3);

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_DIVIDE, ST_STUCK} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d, s_q, s_d, s_prev_q, s_prev_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] den_q, den_d;
  logic [CNT_W:0]   rem_q, rem_d, rem_sub;
  logic [W:0]       quo_q, quo_d, quo_step;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic [W-1:0]     duty_q, duty_d;
  logic             duty_valid_q, duty_valid_d;
  logic             locked_q, locked_d;
  logic             rise, fall, timeout, rem_ge, go_stuck;

  always_comb begin
    sync1_d  = bus.pwm_in;
    s_d      = sync1_q;
    s_prev_d = s_q;
    rise     = s_q & ~s_prev_q;
    fall     = ~s_q & s_prev_q;
    timeout  = (period_cnt_q == LIMIT);

    if (rise) begin
      period_cnt_d = CNT_W'(1);
      high_cnt_d   = CNT_W'(s_q);
    end else begin
      period_cnt_d = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + CNT_W'(1);
      high_cnt_d   = (s_q && high_cnt_q != '1) ? high_cnt_q + CNT_W'(1) : high_cnt_q;
    end

    // high <= period, so the quotient fits W+1 bits and the numerator's low W
    // zero bits are supplied by shifting the remainder; one bit per cycle.
    rem_ge   = (rem_q >= {1'b0, den_q});
    rem_sub  = rem_ge ? rem_q - {1'b0, den_q} : rem_q;
    quo_step = (quo_q << 1) | (W + 1)'(rem_ge);

    state_d      = state_q;
    den_d        = den_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    div_cnt_d    = div_cnt_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    locked_d     = locked_q;
    go_stuck     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rise)         state_d = ST_MEASURE;
        else if (timeout) go_stuck = 1'b1;
      end
      ST_MEASURE: begin
        if (rise) begin
          if (period_cnt_q < MIN_DEN) begin
            locked_d = 1'b0;
          end else begin
            den_d     = period_cnt_q;
            rem_d     = {1'b0, high_cnt_q};
            quo_d     = '0;
            div_cnt_d = DCW'(W);
            state_d   = ST_DIVIDE;
          end
        end else if (timeout) begin
          go_stuck = 1'b1;
        end
      end
      ST_DIVIDE: begin
        rem_d     = rem_sub << 1;
        quo_d     = quo_step;
        div_cnt_d = div_cnt_q - DCW'(1);
        if (div_cnt_q == '0) begin
          duty_d       = quo_step[W] ? '1 : quo_step[W-1:0];
          duty_valid_d = 1'b1;
          locked_d     = 1'b1;
          state_d      = ST_MEASURE;
        end
      end
      ST_STUCK: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (fall) begin
          duty_d       = '0;
          duty_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_stuck) begin
      duty_d       = s_q ? '1 : '0;
      duty_valid_d = 1'b1;
      locked_d     = 1'b0;
      state_d      = ST_STUCK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      s_prev_q     <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      den_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      div_cnt_q    <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      s_q          <= s_d;
      s_prev_q     <= s_prev_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      den_q        <= den_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      div_cnt_q    <= div_cnt_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.locked     = locked_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: directed PWM waveforms, a cycle-level reference model
// computing duty by plain division, and literal checks at the end of each phase.
module tb_pwm_decoder;
  localparam int unsigned W       = 4;
  localparam int unsigned LIMIT   = 4800;
  localparam int unsigned MIN_DEN = W + 3;
  localparam int unsigned MAXCODE = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pwm_decoder_if #(.PWM_WIDTH(W)) bus ();

  pwm_decoder #(
    .CLK_HZ(12_000_000),
    .PWM_PERIOD_US(100),
    .PWM_WIDTH(W),
    .TIMEOUT_PERIODS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned dut_pulses = 0;

  typedef enum {M_IDLE, M_RUN, M_BUSY, M_STUCK} mmode_t;
  mmode_t      mode;
  bit          pa, pb, pc;          // pin as sampled 1, 2, 3 edges ago
  int unsigned den, hc, busy_age, pend;
  logic [W-1:0] exp_duty;
  bit          exp_valid, exp_locked;

  task automatic model_step();
    bit s, sp, rise, fall;
    if (!rst) begin
      mode = M_IDLE; pa = 0; pb = 0; pc = 0;
      den = 0; hc = 0; busy_age = 0; pend = 0;
      exp_duty = '0; exp_valid = 0; exp_locked = 0;
      return;
    end
    s = pb; sp = pc;
    rise = s && !sp;
    fall = !s && sp;
    exp_valid = 0;
    case (mode)
      M_IDLE:
        if (rise) mode = M_RUN;
        else if (den == LIMIT) go_stuck(s);
      M_RUN:
        if (rise) begin
          if (den < MIN_DEN) exp_locked = 0;
          else begin
            pend = (hc << W) / den;
            if (pend > MAXCODE) pend = MAXCODE;
            busy_age = 0;
            mode = M_BUSY;
          end
        end else if (den == LIMIT) go_stuck(s);
      M_BUSY: begin
        busy_age++;
        if (busy_age == W + 1) begin
          exp_duty = W'(pend); exp_valid = 1; exp_locked = 1; mode = M_RUN;
        end
      end
      M_STUCK:
        if (rise) mode = M_RUN;
        else if (fall) begin exp_duty = '0; exp_valid = 1; end
    endcase
    if (rise) begin den = 1; hc = 1; end
    else begin den++; if (s) hc++; end
    pc = pb; pb = pa; pa = bus.pwm_in;
  endtask

  task automatic go_stuck(input bit s);
    exp_duty   = s ? W'(MAXCODE) : '0;
    exp_valid  = 1;
    exp_locked = 0;
    mode       = M_STUCK;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (bus.duty_valid) dut_pulses++;
    n_cmp++;
    if ({bus.duty, bus.duty_valid, bus.locked} !== {exp_duty, exp_valid, exp_locked}) begin
      n_bad++;
      $display("FAIL outputs t=%0t got duty=%0d valid=%0b locked=%0b want duty=%0d valid=%0b locked=%0b",
               $time, bus.duty, bus.duty_valid, bus.locked, exp_duty, exp_valid, exp_locked);
    end
  end

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  task automatic hold(input logic lvl, input int unsigned n);
    bus.pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic periods(input int unsigned h, input int unsigned p, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      hold(1'b1, h);
      if (p > h) hold(1'b0, p - h);
    end
  endtask

  int unsigned p0;

  initial begin
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_duty", bus.duty, 0);
    check("reset_valid", bus.duty_valid, 0);
    check("reset_locked", bus.locked, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    hold(1'b0, 10);

    p0 = dut_pulses;
    periods(300, 1200, 5);
    check("q25_duty", bus.duty, 4);
    check("q25_locked", bus.locked, 1);
    check("q25_pulses", dut_pulses - p0, 4);

    periods(1199, 1200, 3);
    check("near_full_duty", bus.duty, 15);
    p0 = dut_pulses;
    hold(1'b1, 4900);
    check("stuck_hi_duty", bus.duty, 15);
    check("stuck_hi_locked", bus.locked, 0);
    check("stuck_hi_pulses", dut_pulses - p0, 2);
    p0 = dut_pulses;
    hold(1'b0, 100);
    check("stuck_fall_duty", bus.duty, 0);
    check("stuck_fall_pulses", dut_pulses - p0, 1);

    p0 = dut_pulses;
    periods(600, 1200, 5);
    check("half_duty", bus.duty, 8);
    check("half_locked", bus.locked, 1);
    check("half_pulses", dut_pulses - p0, 4);
    p0 = dut_pulses;
    hold(1'b0, 5000);
    check("stuck_lo_duty", bus.duty, 0);
    check("stuck_lo_locked", bus.locked, 0);
    check("stuck_lo_pulses", dut_pulses - p0, 1);
    p0 = dut_pulses;
    periods(150, 600, 5);
    check("p600_duty", bus.duty, 4);
    check("p600_locked", bus.locked, 1);
    check("p600_pulses", dut_pulses - p0, 4);

    periods(300, 1200, 2);
    periods(300, 1194, 1);
    periods(3, 6, 1);
    hold(1'b1, 20);
    check("glitch_unlocked", bus.locked, 0);
    hold(1'b1, 280);
    hold(1'b0, 900);
    periods(300, 1200, 2);
    check("glitch_recover_duty", bus.duty, 4);
    check("glitch_recover_locked", bus.locked, 1);

    periods(300, 1200, 1);
    bus.pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_duty", bus.duty, 0);
    check("abort_valid", bus.duty_valid, 0);
    check("abort_locked", bus.locked, 0);
    @(negedge clk);
    hold(1'b1, 295);
    hold(1'b0, 10);
    #2 rst = 1'b1;
    p0 = dut_pulses;
    @(negedge clk);
    hold(1'b0, 889);
    periods(300, 1200, 1);
    check("abort_no_pulse", dut_pulses - p0, 0);
    periods(300, 1200, 2);
    check("abort_resume_duty", bus.duty, 4);
    check("abort_resume_locked", bus.locked, 1);

    periods(75, 1200, 4);
    check("floor_one", bus.duty, 1);
    periods(74, 1200, 4);
    check("floor_zero", bus.duty, 0);
    check("floor_zero_locked", bus.locked, 1);
    hold(1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receive-side companion to the RGB/LED PWM drivers. Measures an incoming PWM waveform and reports its duty cycle as a `PWM_WIDTH`-bit code, using the same scaling the drivers use (code = high/period × 2^PWM_WIDTH). It detects stuck-high and stuck-low inputs by timeout. It sits between a board pin or internal PWM net and any logic or debug LED that needs the commanded brightness back.

## Interface
- `CLK_HZ`, 12_000_000, clock frequency in Hz.
- `PWM_PERIOD_US`, 100, nominal PWM period.
- `PWM_WIDTH`, 4, duty code width W.
- `PWM_TICKS`, `CLK_HZ*PWM_PERIOD_US/1_000_000` (1200), nominal period in clocks.
- `TIMEOUT_PERIODS`, 4, nominal periods without a rising edge before the input is declared stuck.
- `CNT_W`, `$clog2(PWM_TICKS*TIMEOUT_PERIODS+1)`, counter width.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `pwm_in`  in  1  asynchronous PWM input.
- `duty`  out  W  last measured duty code.
- `duty_valid`  out  1  one-cycle pulse when `duty` updates.
- `locked`  out  1  high while consecutive valid periods are being measured.

## Operation
- `pwm_in` passes through a 2-flop synchronizer to give `s`. A rising edge `rise` is detected from `s` and a registered copy of `s`.
- `period_cnt` and `high_cnt` are both CNT_W wide.
- Every cycle, `period_cnt` increments with saturation. `high_cnt` increments with saturation while `s`=1.
- On `rise`, both counters restart the new period: `period_cnt`←1, and `high_cnt`←1 if `s`=1, otherwise 0.
- **IDLE** (reset state): wait for the first `rise`, then go to MEASURE. No result is produced on this edge.
- **MEASURE**: on `rise`, latch `num = high_cnt` and `den = period_cnt` from the period just ended, then go to DIVIDE.
  - If `den` < W+3, the period is too short. Discard the measurement, set `locked`=0, and stay in MEASURE.
- **DIVIDE**: sequential restoring division of `num << W` by `den`, one quotient bit per cycle, W+1 cycles.
  - Quotient is saturated to 2^W−1 (the case num==den gives 2^W).
  - On completion: `duty`←quotient, pulse `duty_valid`, `locked`←1, return to MEASURE.
  - A `rise` arriving during DIVIDE still restarts the counters. It is not lost as a period start, but its own measurement is skipped. The period minimum makes this case unreachable for legal inputs.
- **Timeout**: in MEASURE or IDLE, when `period_cnt` reaches `PWM_TICKS*TIMEOUT_PERIODS`, go to **STUCK**.
  - `duty` is set to 2^W−1 if `s`=1, otherwise 0.
  - `duty_valid` pulses once and `locked`←0.
- **STUCK**: hold outputs with no further pulses.
  - If `s` changes level without a rising edge (high→low), update `duty` to 0 and pulse `duty_valid` once.
  - A `rise` goes to MEASURE as a first edge, with no result.
- Division arithmetic: numerator is CNT_W+W bits, remainder is CNT_W+1 bits, quotient is W+1 bits before saturation. The result is the floor.

## Timing
- Reset (async assert, sync deassert handled externally):
  - `duty`=0, `duty_valid`=0, `locked`=0.
  - State IDLE, counters 0, synchronizer flops 0.
- Pin-to-`rise` latency: 3 clocks (2 sync + 1 edge register).
- `rise`-to-`duty_valid` latency: 1 clock to enter DIVIDE, plus W+1 divide cycles. Default is 6 clocks.
- `duty` is stable from `duty_valid` until the next `duty_valid`.
- Timeout fires on the cycle `period_cnt` equals the limit. The default limit is 4800 clocks after the last `rise`.
- `rst` asserted mid-DIVIDE aborts immediately. After release, the first edge is treated as a new start: no stale pulse.
- `duty_valid` never pulses on two consecutive cycles.

## Test plan
- Period 1200, high 300 for 5 periods: no pulse on the first edge, then `duty_valid` every 1200 clocks with `duty`=4, `locked`=1 from the first pulse.
- Period 1200, high 1199: `duty`=15, covering the floor of 15.99. Then high 1200, i.e. constant high: after 4800 clocks, STUCK with `duty`=15, a single pulse, and `locked`=0.
- Constant low after a locked 50% stream: `duty`=8 while streaming, then `duty`=0 with one pulse 4800 clocks after the last rise, and `locked`=0. A subsequent stream at period 600, high 150 relocks with `duty`=4.
- Glitch pulse of 3 clocks between valid periods: the short period is discarded, `locked` drops to 0, and it recovers with the correct `duty` on the next full period.
- Assert `rst` 2 clocks after a `rise` (mid-DIVIDE): all outputs are 0 immediately, no `duty_valid` follows, and normal results resume from the second edge after release.
- Period 1200, high 75 with W=4: `duty`=1. Then high 74: `duty`=0, exercising the floor boundary.
